// File: rtl/tl45_hazard_ctrl.sv
// tl45_hazard_ctrl
//   Front-end hazard sequencer for the tl45 pipeline. Keeps an in-order FIFO
//   of destination registers for every instruction issued past decode, stalls
//   decode on read-after-write hazards or a full FIFO, and squashes younger
//   entries plus drives a timed flush when execute redirects.
//
// Handshake: decode presents an instruction with i_dec_valid. It is accepted
//   (o_issue=1) in the same cycle only when the controller is in RUN, no
//   redirect is happening, there is no hazard and the FIFO has room;
//   otherwise o_pipe_stall holds decode (except during a flush, which
//   dominates). Writeback retires the FIFO head with i_wb_valid; it is never
//   back-pressured.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_dec_valid/dr/sr1/sr2 decoded instruction (register 0 = none)
//   i_wb_valid, i_wb_dr    retire of the oldest in-flight instruction
//   i_ex_redirect, i_ex_keep  taken control transfer; oldest entries to keep
//   o_pipe_stall, o_pipe_flush  decode/upstream hold and squash
//   o_issue                decode instruction accepted this cycle
//   o_busy_mask            per-register pending-write bitmap
//   o_sb_err               registered pulse on a retire protocol violation
//   o_pipe_flush doubles as the FSM state (1 = FLUSH).
module tl45_hazard_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_dec_valid,
  input  logic [3:0]                 i_dec_dr,
  input  logic [3:0]                 i_dec_sr1,
  input  logic [3:0]                 i_dec_sr2,
  input  logic                       i_wb_valid,
  input  logic [3:0]                 i_wb_dr,
  input  logic                       i_ex_redirect,
  input  logic [$clog2(DEPTH):0]     i_ex_keep,
  output logic                       o_pipe_stall,
  output logic                       o_pipe_flush,
  output logic                       o_issue,
  output logic [15:0]                o_busy_mask,
  output logic                       o_sb_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic [2:0]         r_flush_cnt, w_flush_cnt_next;
  logic [3:0]         r_fifo_dr [DEPTH];
  logic [PTR_W-1:0]   r_head, r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_sb_err;

  logic [15:0]        w_busy_mask;
  logic               w_hazard, w_full, w_can, w_push, w_pop, w_err;
  logic [CNT_W-1:0]   w_kept, w_redir_count;
  logic [PTR_W-1:0]   w_head_next;

  // Busy bitmap is built only from registered FIFO contents: a retire in
  // cycle N frees its register in cycle N+1.
  always_comb begin
    w_busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < r_count) w_busy_mask[r_fifo_dr[r_head + PTR_W'(k)]] = 1'b1;
    end
    w_busy_mask[0] = 1'b0;
  end

  assign w_hazard = (i_dec_sr1 != 4'd0 && w_busy_mask[i_dec_sr1]) ||
                    (i_dec_sr2 != 4'd0 && w_busy_mask[i_dec_sr2]);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_can    = i_dec_valid && (r_state == ST_RUN) && !i_ex_redirect;
  assign w_push   = w_can && !w_hazard && !w_full;
  assign w_pop    = i_wb_valid && (r_count != '0);
  // Empty-FIFO retire and a destination mismatch are both flagged.
  assign w_err    = i_wb_valid && ((r_count == '0) || (i_wb_dr != r_fifo_dr[r_head]));

  // Redirect: keep the oldest min(keep, count) entries, minus one retiring
  // from the head this same cycle, never below zero.
  assign w_kept        = (i_ex_keep < r_count) ? i_ex_keep : r_count;
  assign w_redir_count = w_pop ? ((w_kept == '0) ? '0 : w_kept - CNT_W'(1)) : w_kept;
  assign w_head_next   = w_pop ? r_head + PTR_W'(1) : r_head;

  // Next-state logic; a redirect in either state (re)loads the flush timer.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    if (i_ex_redirect) begin
      w_state_next     = ST_FLUSH;
      w_flush_cnt_next = 3'(FLUSH_CYCLES - 1);
    end else if (r_state == ST_FLUSH) begin
      if (r_flush_cnt == 3'd0) begin
        w_state_next = ST_RUN;
      end else begin
        w_flush_cnt_next = r_flush_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_sb_err    <= w_err;
      r_head      <= w_head_next;
      if (i_ex_redirect) begin
        // Pointer arithmetic wraps; a full retained FIFO leaves tail == head.
        r_tail  <= w_head_next + w_redir_count[PTR_W-1:0];
        r_count <= w_redir_count;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage needs no reset: only slots inside [head, head+count) are read.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) r_fifo_dr[r_tail] <= i_dec_dr;
  end

  assign o_pipe_stall = w_can && (w_hazard || w_full);
  assign o_issue      = w_push;
  assign o_pipe_flush = (r_state == ST_FLUSH);
  assign o_busy_mask  = w_busy_mask;
  assign o_sb_err     = r_sb_err;

endmodule

// File: tb/tb_tl45_hazard_ctrl.sv
module tb_tl45_hazard_ctrl;
  localparam int DEPTH = 4;
  localparam int FC    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dec_valid, wb_valid, ex_redirect;
  logic [3:0]  dec_dr, dec_sr1, dec_sr2, wb_dr;
  logic [2:0]  ex_keep;
  logic        o_pipe_stall, o_pipe_flush, o_issue, o_sb_err;
  logic [15:0] o_busy_mask;

  tl45_hazard_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_dec_valid(dec_valid), .i_dec_dr(dec_dr), .i_dec_sr1(dec_sr1), .i_dec_sr2(dec_sr2),
    .i_wb_valid(wb_valid), .i_wb_dr(wb_dr),
    .i_ex_redirect(ex_redirect), .i_ex_keep(ex_keep),
    .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush), .o_issue(o_issue),
    .o_busy_mask(o_busy_mask), .o_sb_err(o_sb_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [3:0] exp_q[$];     // in-flight destination registers, oldest first
  int         m_flush_left; // flush cycles still to be shown
  logic       m_err;        // sb_err expected in the current cycle

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    foreach (exp_q[i]) if (exp_q[i] != 4'd0) m[exp_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic model_hazard();
    logic [15:0] m = model_mask();
    return (dec_sr1 != 0 && m[dec_sr1]) || (dec_sr2 != 0 && m[dec_sr2]);
  endfunction

  function automatic logic model_ok();
    return dec_valid && (m_flush_left == 0) && !ex_redirect;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    dec_valid = 0; dec_dr = 0; dec_sr1 = 0; dec_sr2 = 0;
    wb_valid = 0; wb_dr = 0; ex_redirect = 0; ex_keep = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic iss, popped;
    int kept, newc;
    @(posedge clk);
    if (reset) begin
      exp_q.delete(); m_flush_left = 0; m_err = 0;
    end else begin
      iss    = model_ok() && !model_hazard() && (exp_q.size() != DEPTH);
      m_err  = wb_valid && (exp_q.size() == 0 || wb_dr != exp_q[0]);
      popped = wb_valid && (exp_q.size() > 0);
      if (ex_redirect) begin
        kept = (int'(ex_keep) < exp_q.size()) ? int'(ex_keep) : exp_q.size();
        newc = kept - (popped ? 1 : 0);
        if (newc < 0) newc = 0;
        if (popped) void'(exp_q.pop_front());
        while (exp_q.size() > newc) void'(exp_q.pop_back());
        m_flush_left = FC;
      end else begin
        if (popped) void'(exp_q.pop_front());
        if (iss) exp_q.push_back(dec_dr);
        if (m_flush_left > 0) m_flush_left--;
      end
    end
    #1;
  endtask

  task automatic issue_dr(input logic [3:0] dr);
    dec_valid = 1; dec_dr = dr; dec_sr1 = 0; dec_sr2 = 0;
    tick();
    dec_valid = 0;
  endtask

  task automatic retire(input logic [3:0] dr);
    wb_valid = 1; wb_dr = dr;
    tick();
    wb_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); reset = 1;
    tick(); tick();
    reset = 0; settle();
    n_tests++; if (o_pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", o_pipe_stall); end
    n_tests++; if (o_pipe_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", o_pipe_flush); end
    n_tests++; if (o_issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b want 0", o_issue); end
    n_tests++; if (o_busy_mask !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", o_busy_mask); end
    n_tests++; if (o_sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sberr: got %b want 0", o_sb_err); end
  endtask

  task automatic test_raw();
    idle();
    dec_valid = 1; dec_dr = 3; settle();
    n_tests++; if (o_issue !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b want 1", o_issue); end
    tick();
    dec_dr = 6; dec_sr1 = 3; settle();
    n_tests++; if (o_issue !== 1'b0) begin n_fail++; $display("FAIL raw_dep_issue: got %b want 0", o_issue); end
    n_tests++; if (o_pipe_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", o_pipe_stall); end
    n_tests++; if (o_busy_mask !== 16'h0008) begin n_fail++; $display("FAIL raw_busy: got %h want 0008", o_busy_mask); end
    tick(); settle();
    n_tests++; if (o_pipe_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_held: got %b want 1", o_pipe_stall); end
    wb_valid = 1; wb_dr = 3; settle();
    n_tests++; if (o_pipe_stall !== 1'b1) begin n_fail++; $display("FAIL raw_no_bypass: got %b want 1", o_pipe_stall); end
    tick();
    wb_valid = 0; settle();
    n_tests++; if (o_pipe_stall !== 1'b0 || o_issue !== 1'b1) begin n_fail++; $display("FAIL raw_release: got stall=%b issue=%b want 0/1", o_pipe_stall, o_issue); end
    tick();
    dec_valid = 0; dec_sr1 = 0;
    retire(6); settle();
    n_tests++; if (o_sb_err !== 1'b0 || o_busy_mask !== 16'h0) begin n_fail++; $display("FAIL raw_drain: got err=%b busy=%h want 0/0000", o_sb_err, o_busy_mask); end
  endtask

  task automatic test_full();
    logic [3:0] drs[4] = '{4'd1, 4'd2, 4'd4, 4'd5};
    idle();
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1; dec_dr = drs[i]; settle();
      n_tests++; if (o_issue !== 1'b1) begin n_fail++; $display("FAIL full_fill_%0d: got issue=%b want 1", i, o_issue); end
      tick();
    end
    dec_dr = 7; settle();
    n_tests++; if (o_pipe_stall !== 1'b1 || o_issue !== 1'b0) begin n_fail++; $display("FAIL full_stall: got stall=%b issue=%b want 1/0", o_pipe_stall, o_issue); end
    n_tests++; if (o_busy_mask !== 16'h0036) begin n_fail++; $display("FAIL full_busy: got %h want 0036", o_busy_mask); end
    wb_valid = 1; wb_dr = 1; tick();
    wb_valid = 0; settle();
    n_tests++; if (o_busy_mask !== 16'h0034) begin n_fail++; $display("FAIL full_retire_busy: got %h want 0034", o_busy_mask); end
    n_tests++; if (o_issue !== 1'b1 || o_pipe_stall !== 1'b0) begin n_fail++; $display("FAIL full_resume: got issue=%b stall=%b want 1/0", o_issue, o_pipe_stall); end
    tick();
    dec_valid = 0;
    retire(2); retire(4); retire(5); retire(7); settle();
    n_tests++; if (o_busy_mask !== 16'h0 || o_sb_err !== 1'b0) begin n_fail++; $display("FAIL full_drain: got busy=%h err=%b want 0000/0", o_busy_mask, o_sb_err); end
  endtask

  task automatic test_redirect();
    idle();
    issue_dr(1); issue_dr(2); issue_dr(3); issue_dr(4);
    ex_redirect = 1; ex_keep = 2; dec_valid = 1; dec_dr = 9; settle();
    n_tests++; if (o_issue !== 1'b0 || o_pipe_stall !== 1'b0) begin n_fail++; $display("FAIL redir_cycle: got issue=%b stall=%b want 0/0", o_issue, o_pipe_stall); end
    tick();
    ex_redirect = 0; settle();
    n_tests++; if (o_pipe_flush !== 1'b1) begin n_fail++; $display("FAIL redir_flush1: got %b want 1", o_pipe_flush); end
    n_tests++; if (o_busy_mask !== 16'h0006) begin n_fail++; $display("FAIL redir_busy: got %h want 0006", o_busy_mask); end
    n_tests++; if (o_issue !== 1'b0 || o_pipe_stall !== 1'b0) begin n_fail++; $display("FAIL redir_fl1_io: got issue=%b stall=%b want 0/0", o_issue, o_pipe_stall); end
    tick(); settle();
    n_tests++; if (o_pipe_flush !== 1'b1 || o_issue !== 1'b0) begin n_fail++; $display("FAIL redir_flush2: got flush=%b issue=%b want 1/0", o_pipe_flush, o_issue); end
    tick();
    dec_valid = 0; settle();
    n_tests++; if (o_pipe_flush !== 1'b0) begin n_fail++; $display("FAIL redir_flush_end: got %b want 0", o_pipe_flush); end
    retire(1); retire(2); settle();
    n_tests++; if (o_busy_mask !== 16'h0 || o_sb_err !== 1'b0) begin n_fail++; $display("FAIL redir_drain: got busy=%h err=%b want 0000/0", o_busy_mask, o_sb_err); end
  endtask

  task automatic test_redirect_wb();
    idle();
    issue_dr(5); issue_dr(6); issue_dr(7);
    ex_redirect = 1; ex_keep = 3; wb_valid = 1; wb_dr = 5;
    tick();
    wb_valid = 0; ex_redirect = 0; settle();
    n_tests++; if (o_busy_mask !== 16'h00C0 || o_pipe_flush !== 1'b1) begin n_fail++; $display("FAIL redirwb_state: got busy=%h flush=%b want 00c0/1", o_busy_mask, o_pipe_flush); end
    ex_redirect = 1; ex_keep = 2;
    tick();
    ex_redirect = 0; settle();
    n_tests++; if (o_pipe_flush !== 1'b1) begin n_fail++; $display("FAIL redirwb_ext1: got %b want 1", o_pipe_flush); end
    tick(); settle();
    n_tests++; if (o_pipe_flush !== 1'b1) begin n_fail++; $display("FAIL redirwb_ext2: got %b want 1", o_pipe_flush); end
    tick(); settle();
    n_tests++; if (o_pipe_flush !== 1'b0 || o_busy_mask !== 16'h00C0) begin n_fail++; $display("FAIL redirwb_end: got flush=%b busy=%h want 0/00c0", o_pipe_flush, o_busy_mask); end
    retire(6); retire(7); settle();
    n_tests++; if (o_sb_err !== 1'b0 || o_busy_mask !== 16'h0) begin n_fail++; $display("FAIL redirwb_drain: got err=%b busy=%h want 0/0000", o_sb_err, o_busy_mask); end
  endtask

  task automatic test_sb_err();
    idle();
    retire(0); settle();
    n_tests++; if (o_sb_err !== 1'b1) begin n_fail++; $display("FAIL sberr_empty: got %b want 1", o_sb_err); end
    tick(); settle();
    n_tests++; if (o_sb_err !== 1'b0 || o_busy_mask !== 16'h0) begin n_fail++; $display("FAIL sberr_empty_clear: got err=%b busy=%h want 0/0000", o_sb_err, o_busy_mask); end
    issue_dr(2); issue_dr(4);
    retire(7); settle();
    n_tests++; if (o_sb_err !== 1'b1) begin n_fail++; $display("FAIL sberr_mismatch: got %b want 1", o_sb_err); end
    n_tests++; if (o_busy_mask !== 16'h0010) begin n_fail++; $display("FAIL sberr_mismatch_pop: got %h want 0010", o_busy_mask); end
    tick(); settle();
    n_tests++; if (o_sb_err !== 1'b0) begin n_fail++; $display("FAIL sberr_pulse: got %b want 0", o_sb_err); end
    retire(4);
  endtask

  task automatic test_reset_in_flush();
    idle();
    issue_dr(1); issue_dr(2);
    ex_redirect = 1; ex_keep = 2; tick();
    ex_redirect = 0; settle();
    n_tests++; if (o_pipe_flush !== 1'b1) begin n_fail++; $display("FAIL rstfl_pre: got %b want 1", o_pipe_flush); end
    reset = 1; tick();
    reset = 0; settle();
    n_tests++; if (o_pipe_flush !== 1'b0 || o_busy_mask !== 16'h0) begin n_fail++; $display("FAIL rstfl_post: got flush=%b busy=%h want 0/0000", o_pipe_flush, o_busy_mask); end
    wb_valid = 1; wb_dr = 0; tick();
    wb_valid = 0; settle();
    n_tests++; if (o_sb_err !== 1'b1) begin n_fail++; $display("FAIL rstfl_empty: got err=%b want 1", o_sb_err); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] e_mask;
    logic e_ok, e_haz, e_full;
    for (int c = 0; c < 2000; c++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      if (!reset) begin
        dec_valid = ($urandom_range(0, 9) < 6);
        dec_dr    = 4'($urandom_range(0, 7));
        dec_sr1   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 7));
        dec_sr2   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) begin
        wb_valid = 1;
        wb_dr = (exp_q.size() > 0 && $urandom_range(0, 9) != 0) ? exp_q[0] : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 11) == 0) begin
        ex_redirect = 1; ex_keep = 3'($urandom_range(0, DEPTH));
      end
      settle();
      e_mask = model_mask(); e_haz = model_hazard();
      e_full = (exp_q.size() == DEPTH); e_ok = model_ok();
      n_tests++; if (o_busy_mask !== e_mask) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %h want %h", c, o_busy_mask, e_mask); end
      n_tests++; if (o_pipe_stall !== (e_ok && (e_haz || e_full))) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, o_pipe_stall, e_ok && (e_haz || e_full)); end
      n_tests++; if (o_issue !== (e_ok && !e_haz && !e_full)) begin n_fail++; $display("FAIL rnd_issue c=%0d: got %b want %b", c, o_issue, e_ok && !e_haz && !e_full); end
      n_tests++; if (o_pipe_flush !== (m_flush_left > 0)) begin n_fail++; $display("FAIL rnd_flush c=%0d: got %b want %b", c, o_pipe_flush, m_flush_left > 0); end
      n_tests++; if (o_sb_err !== m_err) begin n_fail++; $display("FAIL rnd_sberr c=%0d: got %b want %b", c, o_sb_err, m_err); end
      tick();
    end
    reset = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_flush_left = 0; m_err = 0;
    idle(); reset = 1;
    test_reset();
    test_raw();
    test_full();
    test_redirect();
    test_redirect_wb();
    test_sb_err();
    test_reset_in_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl45_hazard_ctrl.md
Name: tl45_hazard_ctrl

Overview:
- Sequences the tl45 front end by generating `o_pipe_stall` and `o_pipe_flush` for the decode stage and the stages upstream of it.
- Tracks issued register writes in an in-order in-flight FIFO, and stalls decode on RAW hazards or when the FIFO is full.
- On an execute-stage redirect it squashes younger in-flight entries and drives a timed flush.

Parameters:
DEPTH, 4, number of in-flight FIFO entries (power of 2, 2..8)
FLUSH_CYCLES, 2, number of cycles `o_pipe_flush` is held after a redirect (1..7)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_dec_valid  in  1  decode output register holds a real instruction (opcode != 4'hF)
i_dec_dr  in  4  decoded destination register; 0 = no write
i_dec_sr1  in  4  decoded source 1; 0 = unused
i_dec_sr2  in  4  decoded source 2; 0 = unused
i_wb_valid  in  1  writeback retires the oldest in-flight instruction this cycle
i_wb_dr  in  4  destination register of the retiring instruction (consistency check)
i_ex_redirect  in  1  execute resolved a taken GOTO/JALR/SKP this cycle
i_ex_keep  in  clog2(DEPTH)+1  number of oldest FIFO entries to retain on redirect (branch plus older)
o_pipe_stall  out  1  hold decode and upstream stages
o_pipe_flush  out  1  squash decode and upstream stages
o_issue  out  1  decode instruction is accepted into the FIFO this cycle
o_busy_mask  out  16  bit r set when any valid FIFO entry has dr == r (bit 0 always 0)
o_sb_err  out  1  one-cycle pulse on a retire protocol violation

Behaviour:
- Reset (synchronous, active-high):
  - FIFO count 0, head/tail 0, state RUN, flush counter 0.
  - All outputs 0.
  - Reset mid-FLUSH returns to RUN; `o_pipe_flush` is 0 in the cycle after reset.
- State machine, two states:
  - RUN -> FLUSH on `i_ex_redirect`.
  - FLUSH counts FLUSH_CYCLES cycles, then returns to RUN.
  - A redirect while in FLUSH reloads the counter.
- `o_pipe_flush` is a registered output = (state == FLUSH). It is first asserted the cycle after the redirect and stays high for exactly FLUSH_CYCLES cycles.
- Hazard logic is combinational:
  - hazard = (sr1 != 0 && o_busy_mask[sr1]) || (sr2 != 0 && o_busy_mask[sr2]).
  - full = (count == DEPTH).
- Issue and stall:
  - `o_pipe_stall` = `i_dec_valid` && state == RUN && !`i_ex_redirect` && (hazard || full).
  - `o_issue` = `i_dec_valid` && state == RUN && !`i_ex_redirect` && !hazard && !full.
  - `o_pipe_stall` is 0 while in FLUSH, because flush dominates.
- Every issued instruction pushes an entry {dr}, including dr == 0, so the FIFO order matches the pipeline order.
  - Entries with dr == 0 never contribute to `o_busy_mask`.
- Retire:
  - `i_wb_valid` pops the head entry.
  - If count == 0: no pop, and `o_sb_err` pulses.
  - If `i_wb_dr` differs from the head dr: the pop still happens, and `o_sb_err` pulses.
- Redirect:
  - New count = min(`i_ex_keep`, count) − (`i_wb_valid` && count > 0 ? 1 : 0), floored at 0.
  - The tail pointer is moved back accordingly.
  - No push occurs in the redirect cycle.
- Simultaneous push and pop without redirect: count is unchanged and both pointers advance.
- `o_busy_mask` is computed from registered FIFO state only, so retire in cycle N clears the busy bit in cycle N+1. There is no same-cycle bypass.
- Pointers wrap modulo DEPTH. The count field is clog2(DEPTH)+1 bits wide.

Test Plan:
- Reset, then issue ADD dr=3, then a dependent instruction with sr1=3 and no wb:
  - `o_issue`=1 then 0; `o_pipe_stall`=1 held; `o_busy_mask`=16'h0008.
  - wb_dr=3 in cycle N releases the stall in cycle N+1.
- Issue 4 independent writes (dr=1,2,4,5) with no retire:
  - 5th valid instruction sees `o_pipe_stall`=1 (full), `o_busy_mask`=16'h0036.
  - One retire clears bit 1 and issue resumes.
- Count=4 entries (dr=1,2,3,4), `i_ex_redirect`=1, `i_ex_keep`=2, no wb:
  - Next cycle count=2, `o_busy_mask`=16'h0006.
  - `o_pipe_flush`=1 for exactly 2 cycles; `o_issue`=0 throughout.
- Redirect with `i_ex_keep`=3 and `i_wb_valid`=1 on count=3:
  - Resulting count=2 and the head advances.
  - Second redirect during FLUSH extends flush to 2 cycles after it.
- `i_wb_valid`=1 with empty FIFO, then wb_dr=7 against head dr=2:
  - `o_sb_err` pulses one cycle each time; state is otherwise unchanged except the pop in the second case.
- `i_reset` asserted during the first FLUSH cycle: next cycle `o_pipe_flush`=0, count=0, `o_busy_mask`=0.
